// File: rtl/input_conditioner.sv
// input_conditioner: debounces the already-synchronized KEY0/SW0/SW1 levels and
// turns accepted edges into single-cycle event pulses for the NeoPixel FSM.
// KEY0 is active-low at the pin and is presented active-high on keyPressed.
// Optional feature macro: KEY_AUTOREPEAT_EN. When it is defined, keyPress also
// repeats while the key stays held (REPEAT_DELAY, then every REPEAT_PERIOD).

// One debounce channel: STABLE/PENDING FSM plus a stability counter.
module input_conditioner_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic accept_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          differ_s;
    logic          last_s;

    assign differ_s = (raw_i != level_q);
    assign last_s   = (cnt_q == CNT_LAST);

    // State register: FSM state, stability count and accepted level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Next-state logic: any return to the accepted level rejects the bounce.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STABLE: begin
                if (differ_s) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_STABLE;
                end
            end
            ST_PENDING: begin
                if (!differ_s || last_s) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: state_d = ST_STABLE;
        endcase
    end

    // Output logic: counter update, level acceptance and the accept strobe.
    always_comb begin
        cnt_d    = '0;
        level_d  = level_q;
        accept_o = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (differ_s) begin
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_PENDING: begin
                if (!differ_s) begin
                    cnt_d = '0;
                end else if (last_s) begin
                    cnt_d    = '0;
                    level_d  = raw_i;
                    accept_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign level_o = level_q;
endmodule

// Top: three debounce channels, event pulses and optional key auto-repeat.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       syncedKEY0,
    input  logic       syncedSW0,
    input  logic       syncedSW1,
    output logic       keyPressed,
    output logic       keyPress,
    output logic       sw0,
    output logic       sw1,
    output logic [1:0] mode,
    output logic       modeChange
);
    logic raw_key_s;
    logic key_level_s;
    logic key_acc_s;
    logic sw0_level_s;
    logic sw0_acc_s;
    logic sw1_level_s;
    logic sw1_acc_s;
    logic rep_fire_s;
    logic key_press_q;
    logic key_press_d;
    logic mode_change_q;
    logic mode_change_d;

    assign raw_key_s = ~syncedKEY0;

    input_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (raw_key_s),
        .level_o  (key_level_s),
        .accept_o (key_acc_s)
    );

    input_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (syncedSW0),
        .level_o  (sw0_level_s),
        .accept_o (sw0_acc_s)
    );

    input_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (syncedSW1),
        .level_o  (sw1_level_s),
        .accept_o (sw1_acc_s)
    );

`ifdef KEY_AUTOREPEAT_EN
    // rep_cnt_q holds the number of cycles since the press pulse; after the
    // first repeat it cycles REPEAT_DELAY .. REPEAT_DELAY+REPEAT_PERIOD-1.
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RW-1:0] REP_FIRST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_WRAP   = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_ONE    = RW'(1);

    logic [RW-1:0] rep_cnt_q;
    logic [RW-1:0] rep_cnt_d;

    // Repeat counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Repeat timing: runs only while the key stays held (not on the release edge).
    always_comb begin
        rep_cnt_d  = '0;
        rep_fire_s = 1'b0;
        if (key_level_s && !key_acc_s) begin
            if (rep_cnt_q == REP_WRAP) begin
                rep_cnt_d  = REP_RELOAD;
                rep_fire_s = 1'b1;
            end else if (rep_cnt_q == REP_FIRST) begin
                rep_cnt_d  = rep_cnt_q + REP_ONE;
                rep_fire_s = 1'b1;
            end else begin
                rep_cnt_d  = rep_cnt_q + REP_ONE;
                rep_fire_s = 1'b0;
            end
        end else begin
            rep_cnt_d  = '0;
            rep_fire_s = 1'b0;
        end
    end
`else
    // Repeat timing has no effect in this build; fold it into an unused tie-off.
    logic unused_repeat_s;
    assign unused_repeat_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire_s      = 1'b0;
`endif

    // Pulse generation: press edge (or repeat) and any switch acceptance.
    always_comb begin
        key_press_d   = 1'b0;
        mode_change_d = 1'b0;
        if ((key_acc_s && !key_level_s) || rep_fire_s) begin
            key_press_d = 1'b1;
        end else begin
            key_press_d = 1'b0;
        end
        if (sw0_acc_s || sw1_acc_s) begin
            mode_change_d = 1'b1;
        end else begin
            mode_change_d = 1'b0;
        end
    end

    // Pulse registers, aligned with the level flops inside the channels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_press_q   <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            key_press_q   <= key_press_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign keyPressed = key_level_s;
    assign keyPress   = key_press_q;
    assign sw0        = sw0_level_s;
    assign sw1        = sw1_level_s;
    assign mode       = {sw1_level_s, sw0_level_s};
    assign modeChange = mode_change_q;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// A behavioural model (run-length of differing samples) feeds an expected-output
// queue every cycle; table rows and hand sequences add end-of-phase checks.
module tb_input_conditioner;
    localparam int N  = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clock;
    logic       reset;
    logic       syncedKEY0;
    logic       syncedSW0;
    logic       syncedSW1;
    logic       keyPressed;
    logic       keyPress;
    logic       sw0;
    logic       sw1;
    logic [1:0] mode;
    logic       modeChange;

    input_conditioner #(
        .DEBOUNCE_CYCLES (N),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .syncedKEY0 (syncedKEY0),
        .syncedSW0  (syncedSW0),
        .syncedSW1  (syncedSW1),
        .keyPressed (keyPressed),
        .keyPress   (keyPress),
        .sw0        (sw0),
        .sw1        (sw1),
        .mode       (mode),
        .modeChange (modeChange)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {keyPressed, keyPress, sw1, sw0, mode[1:0], modeChange}
    typedef struct {
        logic       rst;
        logic       key0;
        logic       s0;
        logic       s1;
        int         cycles;
        logic [6:0] exp;
    } vec_t;

    vec_t       tbl [18];
    logic [6:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    // reference model state
    logic m_key, m_sw0, m_sw1, m_kp, m_mc;
    int   run_k, run_0, run_1;
`ifdef KEY_AUTOREPEAT_EN
    int   rep_age;
`endif

    function automatic logic [6:0] act_out();
        return {keyPressed, keyPress, sw1, sw0, mode, modeChange};
    endfunction

    function automatic void deb_ch(input logic raw, inout logic deb, inout int run,
                                   output logic chg);
        chg = 1'b0;
        if (raw != deb) begin
            run = run + 1;
            if (run == N) begin
                deb = raw;
                run = 0;
                chg = 1'b1;
            end
        end else begin
            run = 0;
        end
    endfunction

    function automatic void model_step(input logic rst_v, input logic k0,
                                       input logic s0, input logic s1);
        logic ck, c0, c1;
        if (!rst_v) begin
            m_key = 1'b0; m_sw0 = 1'b0; m_sw1 = 1'b0; m_kp = 1'b0; m_mc = 1'b0;
            run_k = 0; run_0 = 0; run_1 = 0;
`ifdef KEY_AUTOREPEAT_EN
            rep_age = 0;
`endif
        end else begin
            deb_ch(~k0, m_key, run_k, ck);
            deb_ch(s0, m_sw0, run_0, c0);
            deb_ch(s1, m_sw1, run_1, c1);
            m_kp = ck & m_key;
            m_mc = c0 | c1;
`ifdef KEY_AUTOREPEAT_EN
            if (m_kp) begin
                rep_age = 0;
            end else if (m_key) begin
                rep_age = rep_age + 1;
                if (rep_age == RD || (rep_age > RD && ((rep_age - RD) % RP) == 0))
                    m_kp = 1'b1;
            end else begin
                rep_age = 0;
            end
`endif
        end
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
    task automatic step(input logic rst_v, input logic k0, input logic s0, input logic s1);
        logic [6:0] e;
        reset      = rst_v;
        syncedKEY0 = k0;
        syncedSW0  = s0;
        syncedSW1  = s1;
        model_step(rst_v, k0, s0, s1);
        exp_q.push_back({m_key, m_kp, m_sw1, m_sw0, m_sw1, m_sw0, m_mc});
        @(negedge clock);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: queue empty, expected one entry");
        end else begin
            e = exp_q.pop_front();
            check("scoreboard", act_out(), e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int pulses;
        int exp_pulses;
        reset = 1'b0; syncedKEY0 = 1'b1; syncedSW0 = 1'b0; syncedSW1 = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0,  3, 7'b0000000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 20, 7'b0000000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0,  3, 7'b0000000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  5, 7'b0000000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0,  4, 7'b1100000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  6, 7'b1000000};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 7'b1000000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 7'b1000000};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,  4, 7'b0000000};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1,  3, 7'b0000000};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 7'b0011111};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1,  5, 7'b0011110};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0,  4, 7'b0001011};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0,  3, 7'b0001010};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 7'b0001010};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 7'b0001010};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0,  3, 7'b0001010};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 7'b0000001};

        for (int i = 0; i < 18; i++) begin
            for (int c = 0; c < tbl[i].cycles; c++)
                step(tbl[i].rst, tbl[i].key0, tbl[i].s0, tbl[i].s1);
            check($sformatf("row%0d", i), act_out(), tbl[i].exp);
        end

        // Long hold: one press pulse, plus repeats when auto-repeat is built.
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            if (keyPress === 1'b1) pulses++;
            if (c == 3) check("press_accept", act_out(), 7'b1100000);
        end
`ifdef KEY_AUTOREPEAT_EN
        exp_pulses = 8;
`else
        exp_pulses = 1;
`endif
        n_vec++;
        if (pulses != exp_pulses) begin
            n_err++;
            $display("FAIL hold_pulses: got %0d, expected %0d", pulses, exp_pulses);
        end
        check("hold_level", act_out(), 7'b1000000);

        // Reset mid-hold clears outputs without waiting for a clock edge.
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_reset", act_out(), 7'b0000000);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // SW1 pending when reset hits: the partial count must be discarded.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("sw1_pending", act_out(), 7'b0000000);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 1'b1);
        check("sw1_restart", act_out(), 7'b0000000);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("sw1_initial_load", act_out(), 7'b0010101);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("sw1_pulse_end", act_out(), 7'b0010100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
